// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment scanner.
package seg_pkg;

  // Scan sequence: SHOW_ONE -> GUARD1 -> SHOW_TEN -> GUARD0 -> SHOW_ONE
  typedef enum logic [1:0] {
    S_SHOW_ONE = 2'd0,
    S_GUARD1   = 2'd1,
    S_SHOW_TEN = 2'd2,
    S_GUARD0   = 2'd3
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low digit enables: an[0] = units, an[1] = tens
  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_ONE = 2'b10;
  localparam logic [1:0] AN_TEN = 2'b01;

endpackage

// File: rtl/seg_scan_if.sv
// Digit inputs and display outputs of the segment scanner.
interface seg_scan_if;
  logic [3:0] one;
  logic [3:0] ten;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  // master: digit source / display consumer; slave: the scanner itself
  modport master (output one, output ten, output blank_lz,
                  input seg, input an, input frame_tick);
  modport slave  (input one, input ten, input blank_lz,
                  output seg, output an, output frame_tick);
endinterface

// File: rtl/seg_decode.sv
// BCD to active-low 7-segment decoder; codes 10-15 decode to all-dark.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, invalid codes fall to dark
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Two-digit multiplexed 7-segment scanner with dark guard slots between
// digits. Digits are captured once per frame so a frame never mixes values.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic      clkin,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int MAXV = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int CW   = $clog2(MAXV);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;
  logic [3:0]    one_q;
  logic [3:0]    ten_q;
  logic          blank_q;
  logic [3:0]    dec_in;
  logic [6:0]    dec_out;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          tick_q;

  // Dwell length of the current state
  always_comb begin
    cnt_last = GUARD_LAST;
    if (state == S_SHOW_ONE || state == S_SHOW_TEN) cnt_last = SCAN_LAST;
  end

  // Decoder feeds the digit about to be shown: in GUARD0 that is the units
  // digit being captured on this edge, in GUARD1 the already-latched tens.
  always_comb begin
    dec_in = ten_q;
    if (state == S_GUARD0) dec_in = bus.one;
  end

  seg_decode u_dec (
    .bcd (dec_in),
    .seg (dec_out)
  );

  // Scan FSM with dwell counter and registered display outputs
  always_ff @(posedge clkin) begin
    if (rst) begin
      state   <= S_GUARD0;
      cnt     <= '0;
      one_q   <= 4'd0;
      ten_q   <= 4'd0;
      blank_q <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (cnt != cnt_last) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
        case (state)
          S_SHOW_ONE: begin
            state <= S_GUARD1;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
          end
          S_GUARD1: begin
            state <= S_SHOW_TEN;
            if (blank_q && ten_q == 4'd0) begin
              an_q  <= AN_OFF;
              seg_q <= SEG_OFF;
            end else begin
              an_q  <= AN_TEN;
              seg_q <= dec_out;
            end
          end
          S_SHOW_TEN: begin
            state <= S_GUARD0;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
          end
          default: begin
            state   <= S_SHOW_ONE;
            one_q   <= bus.one;
            ten_q   <= bus.ten;
            blank_q <= bus.blank_lz;
            an_q    <= AN_ONE;
            seg_q   <= dec_out;
            tick_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, GUARD=2 (12-cycle frames).
module tb_seg_scan;

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seg_scan_if bus ();

  seg_scan #(.SCAN_DIV(4), .GUARD(2)) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clkin = ~clkin;

  // Enables never both on; frame_tick is a single-cycle pulse
  a_an_safe: assert property (@(posedge clkin) disable iff (rst) bus.an != 2'b00);
  a_tick_1:  assert property (@(posedge clkin) disable iff (rst) bus.frame_tick |=> !bus.frame_tick);

  // Hand-written active-low patterns for 0..15
  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Checks one whole frame starting at its first SHOW_ONE cycle; optionally
  // changes the inputs at index chg_at (-1 = never). Leaves the bench at
  // index 0 of the following frame.
  task automatic check_frame(input string name, input logic [6:0] u_seg,
                             input logic [1:0] t_an, input logic [6:0] t_seg,
                             input int chg_at, input logic [3:0] n_one,
                             input logic [3:0] n_ten, input logic n_blank);
    logic [1:0] e_an;
    logic [6:0] e_seg;
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       begin e_an = 2'b10; e_seg = u_seg;  end
      else if (i < 6)  begin e_an = 2'b11; e_seg = 7'h7F;  end
      else if (i < 10) begin e_an = t_an;  e_seg = t_seg;  end
      else             begin e_an = 2'b11; e_seg = 7'h7F;  end
      chk($sformatf("%s[%0d].an", name, i),  {6'd0, bus.an}, {6'd0, e_an});
      chk($sformatf("%s[%0d].seg", name, i), {1'b0, bus.seg}, {1'b0, e_seg});
      chk($sformatf("%s[%0d].tick", name, i), {7'd0, bus.frame_tick}, {7'd0, (i == 0)});
      if (i == chg_at) begin
        bus.one      = n_one;
        bus.ten      = n_ten;
        bus.blank_lz = n_blank;
      end
      step();
    end
  endtask

  initial begin
    bus.one = 4'd3; bus.ten = 4'd7; bus.blank_lz = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst.an",   {6'd0, bus.an}, 8'h03);
    chk("rst.seg",  {1'b0, bus.seg}, 8'h7F);
    chk("rst.tick", {7'd0, bus.frame_tick}, 8'h00);

    // First SHOW_ONE exactly GUARD=2 edges after reset release
    rst = 1'b0;
    step();
    chk("post_rst1.an",   {6'd0, bus.an}, 8'h03);
    chk("post_rst1.tick", {7'd0, bus.frame_tick}, 8'h00);
    step();

    // Basic scan: units 3, tens 7, 12-cycle frame, repeats
    check_frame("f1", 7'h30, 2'b01, 7'h78, -1, 4'd3, 4'd7, 1'b0);
    // Units change during SHOW_TEN must wait for the next frame
    check_frame("f2", 7'h30, 2'b01, 7'h78, 6, 4'd5, 4'd7, 1'b0);
    check_frame("f3", 7'h12, 2'b01, 7'h78, 11, 4'd4, 4'd0, 1'b1);
    // Leading-zero blanking on, then off
    check_frame("f4_blank", 7'h19, 2'b11, 7'h7F, 11, 4'd4, 4'd0, 1'b0);
    check_frame("f5_noblank", 7'h19, 2'b01, 7'h40, 11, 4'd12, 4'd0, 1'b0);
    // Invalid BCD on the units digit
    check_frame("f6_inval", 7'h7F, 2'b01, 7'h40, 3, 4'd12, 4'd9, 1'b0);

    // Reset in the middle of SHOW_TEN (ten=9 latched now)
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst.an", {6'd0, bus.an}, 8'h01);
    rst = 1'b1;
    step();
    chk("mid_rst.an",   {6'd0, bus.an}, 8'h03);
    chk("mid_rst.seg",  {1'b0, bus.seg}, 8'h7F);
    chk("mid_rst.tick", {7'd0, bus.frame_tick}, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    chk("rel.an",   {6'd0, bus.an}, 8'h03);
    chk("rel.tick", {7'd0, bus.frame_tick}, 8'h00);
    step();
    check_frame("f7_after_rst", 7'h7F, 2'b01, exp_seg(4'd9), 11, 4'd0, 4'd15, 1'b0);

    // Decoder sweep: units d with tens 15-d, no blanking
    for (int d = 0; d < 16; d++) begin
      check_frame($sformatf("dec%0d", d), exp_seg(4'(d)), 2'b01, exp_seg(4'(15 - d)),
                  11, 4'(d + 1), 4'(14 - d), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: number of clkin cycles each digit stays lit; legal range >= 2.
REQ-002 Parameter GUARD, default 500: number of clkin cycles both digits are dark between digits (anti-ghosting); legal range >= 1.
REQ-003 clkin  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clkin.
REQ-005 one  input  4  BCD units digit from the two-digit counter.
REQ-006 ten  input  4  BCD tens digit from the two-digit counter.
REQ-007 blank_lz  input  1  when 1, a tens digit of 0 is not lit.
REQ-008 seg  output  7  shared segment bus {g,f,e,d,c,b,a}, active-low (0 = segment on).
REQ-009 an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.
REQ-010 frame_tick  output  1  one-cycle pulse marking the start of each display frame.

Function
REQ-011 The block shall run a four-state FSM cycling SHOW_ONE -> GUARD1 -> SHOW_TEN -> GUARD0 -> SHOW_ONE.
REQ-012 A dwell counter of width clog2(max(SCAN_DIV, GUARD)) shall hold each SHOW state for exactly SCAN_DIV cycles and each GUARD state for exactly GUARD cycles; it clears on every state change.
REQ-013 One frame shall last exactly 2*(SCAN_DIV+GUARD) cycles.
REQ-014 one, ten and blank_lz shall be latched only on the transition GUARD0 -> SHOW_ONE; input changes mid-frame shall not appear until the next frame.
REQ-015 frame_tick shall be 1 in exactly the first cycle of SHOW_ONE, and 0 otherwise.
REQ-016 seg, an and frame_tick shall be registered and shall reflect the new state in the same clock edge on which the state is entered.
REQ-017 In SHOW_ONE: an = 2'b10 and seg = decode(latched one).
REQ-018 In SHOW_TEN: an = 2'b01 and seg = decode(latched ten).
REQ-019 In SHOW_TEN with latched blank_lz = 1 and latched ten = 0: an = 2'b11 and seg = 7'h7F.
REQ-020 In GUARD0 and GUARD1: an = 2'b11 and seg = 7'h7F.
REQ-021 Decode mapping, active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-022 Decode of BCD codes 10-15 shall give 7'h7F (dark); the invalid code shall never propagate elsewhere.
REQ-023 an shall never be 2'b00 in any cycle.

Reset
REQ-024 While rst = 1 at a clock edge, the following shall be set: state = GUARD0, dwell counter = 0, latched digits = 0, latched blank_lz = 0, an = 2'b11, seg = 7'h7F, frame_tick = 0.
REQ-025 After rst deasserts, the first SHOW_ONE shall be entered GUARD cycles later, with frame_tick pulsing on that edge.
REQ-026 Reset asserted in any state shall take priority over all FSM activity and shall abort the frame immediately; no partial dwell is retained.

Structure
REQ-027 A shared package seg_pkg shall hold:
- the FSM state enumeration;
- the ten segment-pattern constants;
- the SEG_OFF constant (7'h7F);
- the AN_OFF constant (2'b11).
REQ-028 A single combinational sub-module seg_decode (4-bit BCD in, 7-bit active-low out) shall be instantiated once, fed by a mux of the latched digit selected by the current state.

Verification
REQ-029 Reset check: assert rst for 3 cycles mid-SHOW_TEN -> the next cycle shows an=2'b11, seg=7'h7F, frame_tick=0; with GUARD=2, SHOW_ONE is entered exactly 2 cycles after rst falls.
REQ-030 Scan timing, SCAN_DIV=4, GUARD=2, one=3, ten=7: an runs 10 x4, 11 x2, 01 x4, 11 x2 and repeats; seg=7'h30 during units and 7'h78 during tens; frame_tick period = 12 cycles.
REQ-031 Mid-frame stability: change one 3->5 during SHOW_TEN -> seg stays 7'h30 for the rest of the frame; 7'h12 appears only from the next frame_tick.
REQ-032 Leading-zero blanking: ten=0, one=4, blank_lz=1 -> tens slot shows an=2'b11, seg=7'h7F; with blank_lz=0 -> an=2'b01, seg=7'h40.
REQ-033 Invalid BCD: one=12 -> units slot shows an=2'b10, seg=7'h7F.
REQ-034 A concurrent assertion shall check an != 2'b00 and frame_tick width = 1 cycle throughout all scenarios.
